// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder: synchronous RAM read into a 2-entry in-order response FIFO.
// Optional IMEM_FLUSH_EN adds a flush port that drops buffered responses.
module imem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_instr,
    output logic                  rsp_err,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data
`ifdef IMEM_FLUSH_EN
    ,
    input  logic                  flush
`endif
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic [31:0] buf_instr_q [0:1];
    logic        buf_err_q   [0:1];

    logic [1:0] count_q, count_d;
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;

    logic                  accept;
    logic                  pop;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] word_idx;

    assign word_idx = req_addr[DEPTH_LOG2+1:2];
    assign req_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:DEPTH_LOG2+2] != '0);

    // rst is folded in so the port reads not-ready for the whole reset pulse.
    assign req_ready = (count_q != 2'd2) && !ld_en && !rst;
    assign rsp_valid = (count_q != 2'd0);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_instr = rsp_valid ? buf_instr_q[rptr_q] : 32'h0;
    assign rsp_err   = rsp_valid ? buf_err_q[rptr_q]   : 1'b0;

    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (accept) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
`ifdef IMEM_FLUSH_EN
        // A request accepted alongside flush is the redirect target and becomes the sole head.
        if (flush) begin
            rptr_d  = wptr_q;
            count_d = accept ? 2'd1 : 2'd0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
        end
    end

    // RAM and buffer payload carry no reset; the read lands directly in the FIFO tail.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (accept) begin
            buf_instr_q[wptr_q] <= req_err ? NOP_INSTR : mem[word_idx];
            buf_err_q[wptr_q]   <= req_err;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - table-driven directed bench for imem_responder plus reset/flush sequences.
module tb_imem_responder;

    localparam logic [31:0] I0  = 32'h0050_0093;
    localparam logic [31:0] I1  = 32'h00A0_0113;
    localparam logic [31:0] I2  = 32'h0020_81B3;
    localparam logic [31:0] I3  = 32'h0000_0013;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] NEW = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        flush;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    imem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
`ifdef IMEM_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        ld;
        logic [9:0]  la;
        logic [31:0] ldd;
        logic        e_rdy;
        logic        e_val;
        logic [31:0] e_instr;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rv, input logic [31:0] ra, input logic rr,
                       input logic ld, input logic [9:0] la, input logic [31:0] ldd,
                       input logic e_rdy, input logic e_val, input logic [31:0] e_instr,
                       input logic e_err);
        vec_t v;
        v.rv = rv; v.ra = ra; v.rr = rr; v.ld = ld; v.la = la; v.ldd = ldd;
        v.e_rdy = e_rdy; v.e_val = e_val; v.e_instr = e_instr; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_out(input string tag, input logic e_rdy, input logic e_val,
                           input logic [31:0] e_instr, input logic e_err);
        chk({tag, ".req_ready"}, {31'b0, req_ready}, {31'b0, e_rdy});
        chk({tag, ".rsp_valid"}, {31'b0, rsp_valid}, {31'b0, e_val});
        chk({tag, ".rsp_instr"}, rsp_instr, e_instr);
        chk({tag, ".rsp_err"},   {31'b0, rsp_err},   {31'b0, e_err});
    endtask

    task automatic drive(input logic rv, input logic [31:0] ra, input logic rr);
        req_valid = rv; req_addr = ra; rsp_ready = rr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 0; req_addr = 0; rsp_ready = 0;
        ld_en = 0; ld_addr = 0; ld_data = 0; flush = 0;

        // first request right out of reset: misaligned, so the response is deterministic
        add(1, 32'h6, 1, 0, 0, 0,      1, 0, 0,   0);
        add(0, 0,     1, 0, 0, 0,      1, 1, NOP, 1);
        add(0, 0,     1, 0, 0, 0,      1, 0, 0,   0);
        // program load; ld_en blocks the concurrent request
        add(1, 0,     1, 1, 0, I0,     0, 0, 0,   0);
        add(0, 0,     1, 1, 1, I1,     0, 0, 0,   0);
        add(0, 0,     1, 1, 2, I2,     0, 0, 0,   0);
        add(0, 0,     1, 1, 3, I3,     0, 0, 0,   0);
        // back-to-back streaming
        add(1, 0,     1, 0, 0, 0,      1, 0, 0,   0);
        add(1, 4,     1, 0, 0, 0,      1, 1, I0,  0);
        add(1, 8,     1, 0, 0, 0,      1, 1, I1,  0);
        add(1, 12,    1, 0, 0, 0,      1, 1, I2,  0);
        add(0, 0,     1, 0, 0, 0,      1, 1, I3,  0);
        add(0, 0,     1, 0, 0, 0,      1, 0, 0,   0);
        // backpressure: two accepts then stall, head held
        add(1, 0,     0, 0, 0, 0,      1, 0, 0,   0);
        add(1, 4,     0, 0, 0, 0,      1, 1, I0,  0);
        add(1, 8,     0, 0, 0, 0,      0, 1, I0,  0);
        add(1, 8,     0, 0, 0, 0,      0, 1, I0,  0);
        add(1, 8,     1, 0, 0, 0,      0, 1, I0,  0);
        add(1, 8,     1, 0, 0, 0,      1, 1, I1,  0);
        add(0, 0,     1, 0, 0, 0,      1, 1, I2,  0);
        add(0, 0,     1, 0, 0, 0,      1, 0, 0,   0);
        // error responses interleaved with good ones
        add(1, 4,          1, 0, 0, 0, 1, 1'b0, 0,   0);
        add(1, 32'h6,      1, 0, 0, 0, 1, 1,    I1,  0);
        add(1, 32'h1000,   1, 0, 0, 0, 1, 1,    NOP, 1);
        add(1, 8,          1, 0, 0, 0, 1, 1,    NOP, 1);
        add(0, 0,          1, 0, 0, 0, 1, 1,    I2,  0);
        add(0, 0,          1, 0, 0, 0, 1, 0,    0,   0);
        // load vs read ordering on word 2
        add(1, 8,     1, 0, 0, 0,      1, 0, 0,   0);
        add(1, 8,     1, 1, 2, NEW,    0, 1, I2,  0);
        add(1, 8,     1, 0, 0, 0,      1, 0, 0,   0);
        add(0, 0,     1, 0, 0, 0,      1, 1, NEW, 0);
        add(0, 0,     1, 0, 0, 0,      1, 0, 0,   0);

        #2;
        chk_out("reset", 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rv, vecs[i].ra, vecs[i].rr);
            ld_en = vecs[i].ld; ld_addr = vecs[i].la; ld_data = vecs[i].ldd;
            #2;
            chk_out($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_val,
                    vecs[i].e_instr, vecs[i].e_err);
            next_cycle();
        end
        ld_en = 0;

        // asynchronous reset with a full buffer
        drive(1, 0, 0); next_cycle();
        drive(1, 4, 0); next_cycle();
        drive(0, 0, 0);
        #2;
        chk_out("full_before_rst", 0, 1, I0, 0);
        #1 rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
        drive(1, 4, 1);
        #2;
        chk_out("post_rst_accept", 1, 0, 0, 0);
        next_cycle();
        drive(0, 0, 1);
        #2;
        chk_out("post_rst_rsp", 1, 1, I1, 0);
        next_cycle();
        #2;
        chk_out("post_rst_empty", 1, 0, 0, 0);
        next_cycle();

`ifdef IMEM_FLUSH_EN
        // flush with a full buffer drops both entries
        drive(1, 0, 0); next_cycle();
        drive(1, 4, 0); next_cycle();
        drive(1, 8, 1); flush = 1;
        #2;
        chk_out("flush_full", 0, 1, I0, 0);
        next_cycle();
        flush = 0; drive(0, 0, 0);
        #2;
        chk_out("flush_full_after", 1, 0, 0, 0);
        // flush with a pending entry and a same-cycle accept of addr 8
        next_cycle();
        drive(1, 0, 0); next_cycle();
        drive(1, 8, 1); flush = 1;
        #2;
        chk_out("flush_accept", 1, 1, I0, 0);
        next_cycle();
        flush = 0; drive(0, 0, 1);
        #2;
        chk_out("flush_target", 1, 1, I2, 0);
        next_cycle();
        #2;
        chk_out("flush_drained", 1, 0, 0, 0);
        next_cycle();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
